// File: rtl/resamp_out_fifo.sv
// Output FIFO after the Farrow rate changer: first-word fall-through queue with
// valid/ready read side, fill level, and sticky overflow with saturating drop count.
module resamp_out_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] x_in,
    input  logic                x_stb,
    output logic signed [W-1:0] y_out,
    output logic                y_valid,
    input  logic                y_ready,
    output logic [AW:0]         level,
    output logic                full,
    output logic                empty,
    output logic                ovf,
    output logic [7:0]          drop_cnt,
    input  logic                clr_ovf
);

    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    logic signed [W-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_level;
    logic                r_ovf;
    logic [7:0]          r_drop_cnt;

    logic w_full;
    logic w_empty;
    logic w_rd;
    logic w_wr;
    logic w_drop;

    always_comb begin
        w_full  = (r_level == LP_FULL);
        w_empty = (r_level == '0);
        w_rd    = !w_empty && y_ready;
        // a read in the same cycle frees the slot, so a full buffer can still accept
        w_wr    = x_stb && (!w_full || w_rd);
        w_drop  = x_stb && w_full && !w_rd;
    end

    always_ff @(posedge clk) begin
        if (!reset && w_wr) begin
            r_mem[r_wr_ptr] <= x_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clr_ovf) begin
            // a drop coinciding with the clear is counted after the clear
            r_ovf      <= w_drop;
            r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        y_out    = w_empty ? '0 : r_mem[r_rd_ptr];
        y_valid  = !w_empty;
        level    = r_level;
        full     = w_full;
        empty    = w_empty;
        ovf      = r_ovf;
        drop_cnt = r_drop_cnt;
    end

endmodule

// File: tb/tb_resamp_out_fifo.sv
// Bench for resamp_out_fifo: vector table, directed corner sequences and random
// traffic, all checked against a queue-based reference model.
module tb_resamp_out_fifo;

    localparam int W     = 9;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [W-1:0] x_in;
    logic                x_stb;
    logic signed [W-1:0] y_out;
    logic                y_valid;
    logic                y_ready;
    logic [AW:0]         level;
    logic                full;
    logic                empty;
    logic                ovf;
    logic [7:0]          drop_cnt;
    logic                clr_ovf;

    resamp_out_fifo #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .x_stb(x_stb),
        .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready),
        .level(level), .full(full), .empty(empty),
        .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: the queue contents, overflow flag and drop count
    int q[$];
    bit m_ovf = 1'b0;
    int m_drop = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit stb, input int x, input bit rdy, input bit clr);
        bit rd, fl, dropped;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_drop = 0;
        end else begin
            fl = (q.size() == DEPTH);
            rd = (q.size() > 0) && rdy;
            dropped = 1'b0;
            if (rd) void'(q.pop_front());
            if (stb) begin
                if (!fl || rd) q.push_back(x);
                else dropped = 1'b1;
            end
            if (clr) begin
                m_ovf = dropped;
                m_drop = dropped ? 1 : 0;
            end else if (dropped) begin
                m_ovf = 1'b1;
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
        end
    endtask

    task automatic check_model();
        int sz;
        sz = q.size();
        chk("level", int'(level), sz);
        chk("y_valid", int'(y_valid), (sz > 0) ? 1 : 0);
        chk("y_out", int'(y_out), (sz > 0) ? q[0] : 0);
        chk("full", int'(full), (sz == DEPTH) ? 1 : 0);
        chk("empty", int'(empty), (sz == 0) ? 1 : 0);
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("drop_cnt", int'(drop_cnt), m_drop);
    endtask

    // one clock: drive inputs, advance the model, then compare just after the edge
    task automatic cyc(input bit rst, input bit stb, input int x, input bit rdy, input bit clr);
        int xv;
        xv = x;
        reset = rst; x_stb = stb; x_in = xv[W-1:0]; y_ready = rdy; clr_ovf = clr;
        model_step(rst, stb, x, rdy, clr);
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit rst; bit stb; int x; bit rdy; bit clr;
        int e_level; bit e_valid; int e_yout; bit e_ovf; int e_drop;
    } vec_t;

    vec_t vecs[10];
    int max_level;
    int rnd_x;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; x_stb = 1'b0; x_in = '0; y_ready = 1'b0; clr_ovf = 1'b0;

        // hand-derived vectors, expected values are the state after the edge
        vecs[0] = '{1, 0,   0, 0, 0, 0, 0,   0, 0, 0};
        vecs[1] = '{0, 1,  10, 1, 0, 1, 1,  10, 0, 0};
        vecs[2] = '{0, 0,   0, 1, 0, 0, 0,   0, 0, 0};
        vecs[3] = '{0, 1, -20, 0, 0, 1, 1, -20, 0, 0};
        vecs[4] = '{0, 1,  30, 0, 0, 2, 1, -20, 0, 0};
        vecs[5] = '{0, 0,   0, 1, 0, 1, 1,  30, 0, 0};
        vecs[6] = '{0, 1, -40, 1, 0, 1, 1, -40, 0, 0};
        vecs[7] = '{0, 0,   0, 1, 0, 0, 0,   0, 0, 0};
        vecs[8] = '{0, 1,   5, 1, 1, 1, 1,   5, 0, 0};
        vecs[9] = '{1, 1,  77, 1, 0, 0, 0,   0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].rst, vecs[i].stb, vecs[i].x, vecs[i].rdy, vecs[i].clr);
            chk("vec_level", int'(level), vecs[i].e_level);
            chk("vec_valid", int'(y_valid), int'(vecs[i].e_valid));
            chk("vec_yout", int'(y_out), vecs[i].e_yout);
            chk("vec_ovf", int'(ovf), int'(vecs[i].e_ovf));
            chk("vec_drop", int'(drop_cnt), vecs[i].e_drop);
        end

        // strobe every 4 clocks with a ready consumer
        cyc(1, 0, 0, 0, 0);
        max_level = 0;
        for (int i = 0; i < 4; i++) begin
            int v;
            v = (i % 2 == 0) ? 10 * (i + 1) : -10 * (i + 1);
            cyc(0, 1, v, 1, 0);
            chk("stb_valid", int'(y_valid), 1);
            chk("stb_yout", int'(y_out), v);
            if (int'(level) > max_level) max_level = int'(level);
            for (int k = 0; k < 3; k++) begin
                cyc(0, 0, 0, 1, 0);
                if (int'(level) > max_level) max_level = int'(level);
            end
        end
        chk("max_level", max_level, 1);
        chk("stream_ovf", int'(ovf), 0);

        // fill, overflow by one, drain
        for (int i = 1; i <= 8; i++) cyc(0, 1, i, 0, 0);
        chk("fill_level", int'(level), 8);
        chk("fill_full", int'(full), 1);
        cyc(0, 1, 9, 0, 0);
        chk("ovf_set", int'(ovf), 1);
        chk("drop_one", int'(drop_cnt), 1);
        chk("ovf_level", int'(level), 8);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", int'(y_out), i);
            cyc(0, 0, 0, 1, 0);
        end
        chk("drain_empty", int'(empty), 1);

        // full with simultaneous read and write
        cyc(0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) cyc(0, 1, i, 0, 0);
        cyc(0, 1, 100, 1, 0);
        chk("rw_full_level", int'(level), 8);
        chk("rw_full_drop", int'(drop_cnt), 0);
        chk("rw_full_head", int'(y_out), 2);
        for (int i = 0; i < 8; i++) begin
            chk("rw_drain", int'(y_out), (i < 7) ? i + 2 : 100);
            cyc(0, 0, 0, 1, 0);
        end
        chk("rw_empty", int'(empty), 1);

        // saturating drop count and clear interplay
        for (int i = 1; i <= 8; i++) cyc(0, 1, i, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 1, 50, 0, 0);
        chk("drop_sat", int'(drop_cnt), 255);
        cyc(0, 1, 51, 0, 1);
        chk("clr_drop_ovf", int'(ovf), 1);
        chk("clr_drop_cnt", int'(drop_cnt), 1);
        cyc(0, 0, 0, 0, 1);
        chk("clr_ovf", int'(ovf), 0);
        chk("clr_cnt", int'(drop_cnt), 0);
        chk("clr_keeps_data", int'(level), 8);

        // reset mid-operation with a strobe in the reset cycle
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 60 + i, 0, 0);
        cyc(1, 1, 99, 1, 0);
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_valid", int'(y_valid), 0);
        chk("rst_yout", int'(y_out), 0);
        cyc(0, 0, 0, 1, 0);
        chk("rst_not_stored", int'(empty), 1);

        // random traffic, pointers wrap many times
        for (int i = 0; i < 600; i++) begin
            rnd_x = int'($urandom_range(0, 511)) - 256;
            cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 1) == 1), rnd_x,
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/resamp_out_fifo.md
Name: resamp_out_fifo

Overview:
- Output buffer placed directly downstream of the Farrow rate changer.
- Captures each interpolated 9-bit sample on a strobe that arrives every 4 clk (rate R=3/4 of input). Hands samples to the next consumer over a valid/ready handshake.
- Absorbs consumer stalls, reports fill level, and flags and counts samples lost to overflow.

Parameters:
- W, 9, sample width in bits (signed, two's complement)
- DEPTH, 8, number of storage entries; power of 2, minimum 2
- AW, 3, pointer width = log2(DEPTH)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state at the next clk edge
- x_in  in  W  signed sample from upstream resampler
- x_stb  in  1  write strobe; high for one cycle when x_in holds a new sample
- y_out  out  W  signed head-of-queue sample
- y_valid  out  1  y_out holds a valid sample
- y_ready  in  1  consumer accepts y_out this cycle
- level  out  AW+1  number of stored entries, range 0..DEPTH
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- ovf  out  1  sticky overflow flag
- drop_cnt  out  8  saturating count of dropped samples
- clr_ovf  in  1  clears ovf and drop_cnt

Behaviour:
- Storage: circular buffer mem[0..DEPTH-1] with wr_ptr and rd_ptr, each AW bits and wrapping modulo DEPTH. level is a separate AW+1-bit register.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, ovf=0, drop_cnt=0. Outputs: y_valid=0, empty=1, full=0, y_out=0. Memory contents are not cleared; y_out is forced to 0 while empty.
- Write event wr = x_stb && (!full || rd).
- Read event rd = y_valid && y_ready.
- On wr: mem[wr_ptr] <= x_in; wr_ptr++.
- On rd: rd_ptr++.
- level update:
  - +1 on wr only
  - -1 on rd only
  - unchanged on both or neither
- y_out = mem[rd_ptr] when !empty, else 0. This is combinational from registered state (first-word fall-through).
- y_valid = !empty, full = (level==DEPTH), empty = (level==0), all derived from the level register.
- Latency: x_stb in cycle N with the buffer empty gives y_valid=1 and y_out=x_in(N) in cycle N+1. There is no combinational path from x_stb or x_in to any output.
- Full with simultaneous read: the write is accepted, level stays DEPTH, no drop.
- Full without read: x_stb drops the sample. Pointers and level are unchanged, ovf <= 1, drop_cnt <= drop_cnt+1, saturating at 255.
- Empty: y_ready is ignored and rd_ptr does not move. A write into an empty buffer with y_ready=1 is not readable in the same cycle.
- clr_ovf:
  - Alone: ovf <= 0, drop_cnt <= 0.
  - Same cycle as a drop: ovf <= 1, drop_cnt <= 1 (the new drop is counted after the clear).
  - Does not affect stored data.
- y_out and y_valid hold stable while y_valid=1 and y_ready=0.
- Reset mid-operation: all queued samples are discarded. x_stb during the reset cycle is ignored. Normal operation resumes the cycle after reset deasserts.
- Pointer wrap: after DEPTH writes wr_ptr returns to 0. Data order is strictly FIFO across the wrap.
- Data is stored and passed unmodified; no sign extension, truncation or rounding.

Test Plan:
- Reset, then x_stb every 4 clk with values 10,-20,30,-40 and y_ready=1 -> each value on y_out with y_valid=1 exactly one cycle after its strobe; level never exceeds 1; ovf=0.
- y_ready=0, write 8 samples 1..8 -> level=8, full=1. 9th strobe (value 9) -> dropped, ovf=1, drop_cnt=1. Then y_ready=1 -> reads 1..8 in order, empty=1 afterwards.
- Full with y_ready=1 and x_stb in the same cycle (value 100) -> sample 1 leaves, 100 is accepted, level stays 8, no drop. Draining yields 2..8 then 100.
- Hold y_ready=0 and strobe 300 times into a full buffer -> drop_cnt saturates at 255. Then clr_ovf=1 together with a strobe -> ovf=1, drop_cnt=1. Then clr_ovf alone -> ovf=0, drop_cnt=0.
- Write 5 samples, assert reset for 1 cycle with x_stb=1 -> next cycle level=0, empty=1, y_valid=0, y_out=0; the strobed sample is not stored.
- 20 writes and reads interleaved so the pointers wrap twice, with random y_ready -> output sequence identical to the input sequence; level equals writes minus reads every cycle.
